// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: default operand
// width and the start/load/shift/done FSM encoding.
package serial_arith_pkg;

  localparam int SERIAL_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out of this bit.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing A - B LSB first through one borrow flop.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_sub_o.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clock_sub_i,
  input  logic             resetn_sub_i,
  input  logic             start_sub_i,
  input  logic [WIDTH-1:0] a_sub_i,
  input  logic [WIDTH-1:0] b_sub_i,
  output logic [WIDTH:0]   diff_sub_o,
  output logic             busy_sub_o,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf_sub_o,
`endif
  output logic             done_sub_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sub_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH:0]   r_diff;
  logic             r_done;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic w_d;
  logic w_bout;

  full_subtractor u_fs (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_ff @(posedge clock_sub_i) begin
    if (!resetn_sub_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_sub_i) r_state <= LOAD;
        end
        LOAD: begin
          r_a     <= a_sub_i;
          r_b     <= b_sub_i;
          r_br    <= 1'b0;
          r_cnt   <= '0;
          r_state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          // Operand MSBs are shifted out, so keep them for the overflow test.
          r_a_msb <= a_sub_i[WIDTH-1];
          r_b_msb <= b_sub_i[WIDTH-1];
`endif
        end
        SHIFT: begin
          if (start_sub_i) begin
            r_state <= LOAD;
          end else begin
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_br  <= w_bout;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_CNT) r_state <= DONE;
          end
        end
        DONE: begin
          r_diff  <= {r_br, r_res};
          r_done  <= 1'b1;
          r_state <= start_sub_i ? LOAD : IDLE;
`ifdef SERIAL_SUB_OVF_EN
          r_ovf   <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign diff_sub_o = r_diff;
  assign done_sub_o = r_done;
  assign busy_sub_o = (r_state == LOAD) || (r_state == SHIFT);
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_sub_o  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table, abort and reset
// sequences, then back-to-back random operations against a reference model.
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int W = SERIAL_WIDTH;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W:0]   diff;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic mon_en = 1'b0;
  logic [W+1:0] exp_q[$];

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   diff;
    logic         ovf;
  } vec_t;
  vec_t vecs[7];

  serial_subtractor #(.WIDTH(W)) dut (
    .clock_sub_i  (clk),
    .resetn_sub_i (resetn),
    .start_sub_i  (start),
    .a_sub_i      (a_in),
    .b_sub_i      (b_in),
    .diff_sub_o   (diff),
    .busy_sub_o   (busy),
`ifdef SERIAL_SUB_OVF_EN
    .ovf_sub_o    (ovf),
`endif
    .done_sub_o   (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned difference modulo 2^(W+1); overflow from signed range.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    int sa, sb, sd;
    logic o;
    d  = {1'b0, a} - {1'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    sd = sa - sb;
    o  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    return {o, d};
  endfunction

  // driver tasks
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge right after the start edge; edges = -1 on timeout.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = -1;
    busy_cnt = busy ? 1 : 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        edges = j;
        break;
      end
    end
  endtask

  task automatic run_dir(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] ed, input logic eo);
    int edges, bc;
    start_op(a, b);
    wait_done(edges, bc);
    check({nm, "_latency"}, edges, W + 2);
    check({nm, "_busy_cycles"}, bc, W + 1);
    check({nm, "_diff"}, 32'(diff), 32'(ed));
`ifdef SERIAL_SUB_OVF_EN
    check({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo) begin end
`endif
    @(negedge clk);
    check({nm, "_done_pulse"}, 32'(done), 0);
    check({nm, "_diff_held"}, 32'(diff), 32'(ed));
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (mon_en && done) begin
      if (exp_q.size() == 0) begin
        check("rand_unexpected_done", 1, 0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        pops++;
        check("rand_diff", 32'(diff), 32'(e[W:0]));
`ifdef SERIAL_SUB_OVF_EN
        check("rand_ovf", 32'(ovf), 32'(e[W+1]));
`endif
      end
    end
  end

  initial begin
    int edges, bc, ndone;
    logic [W-1:0] ra, rb;

    vecs[0] = '{"basic",    8'd5,   8'd3,   9'h002, 1'b0};
    vecs[1] = '{"borrow",   8'd3,   8'd5,   9'h1FE, 1'b0};
    vecs[2] = '{"zero",     8'h00,  8'h00,  9'h000, 1'b0};
    vecs[3] = '{"ff_m_0",   8'hFF,  8'h00,  9'h0FF, 1'b0};
    vecs[4] = '{"0_m_ff",   8'h00,  8'hFF,  9'h101, 1'b0};
    vecs[5] = '{"neg_ovf",  8'h80,  8'h01,  9'h07F, 1'b1};
    vecs[6] = '{"pos_ovf",  8'h7F,  8'hFF,  9'h180, 1'b1};

    resetn = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (2) @(negedge clk);
    check("reset_diff", 32'(diff), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(ovf), 0);
`endif
    resetn = 1'b1;

    foreach (vecs[i]) run_dir(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].ovf);

    // abort: restart three cycles into SHIFT
    start_op(8'd1, 8'd2);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a_in  = 8'd10;
    b_in  = 8'd4;
    @(negedge clk);
    start = 1'b0;
    check("abort_diff_kept", 32'(diff), 32'(9'h180));
    wait_done(edges, bc);
    check("abort_latency", edges, W + 2);
    check("abort_diff", 32'(diff), 32'(9'h006));
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_extra_done", ndone, 0);

    // reset in the middle of SHIFT
    start_op(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst_diff", 32'(diff), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_dir("after_rst", 8'd5, 8'd3, 9'h002, 1'b0);

    // random back-to-back, start re-asserted in DONE
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(0, 255));
      exp_q.push_back(model(ra, rb));
      start = 1'b1;
      a_in  = ra;
      b_in  = rb;
      @(negedge clk);
      start = 1'b0;
      repeat (W + 1) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    check("rand_pending", exp_q.size(), 0);
    check("rand_count", pops, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
